// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data wins ties,
// but a starvation counter forces one fetch grant after STARVE_MAX back-to-back data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IGNT = 2'b01,
    DGNT = 2'b10
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state, next_state;
  logic [3:0] starve_cnt, next_cnt;
  logic       i_req, d_req;

  assign i_req = iREN & ~halt;
  assign d_req = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = starve_cnt;
    case (state)
      IDLE: begin
        if (i_req && starve_cnt == SMAX) begin
          next_state = IGNT;
          next_cnt   = '0;
        end else if (d_req) begin
          next_state = DGNT;
          // Only data grants that overtake a live fetch request count as starvation.
          if (!i_req)
            next_cnt = '0;
          else if (starve_cnt < SMAX)
            next_cnt = starve_cnt + 4'd1;
        end else if (i_req) begin
          next_state = IGNT;
          next_cnt   = '0;
        end else begin
          next_cnt = '0;
        end
      end
      IGNT, DGNT: begin
        if (ramready)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    iload    = '0;
    dhit     = 1'b0;
    dload    = '0;
    case (state)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        ihit    = ramready;
        iload   = ramready ? ramload : '0;
      end
      DGNT: begin
        // A simultaneous read and write is treated as a write.
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dhit     = ramready;
        dload    = (ramready && dREN && !dWEN) ? ramload : '0;
      end
      default: ;
    endcase
  end

  assign grant = state;

endmodule
